add_cmp_div_unit: RTL and testbench

Integer datapath slice for the ALU: combinational add/subtract, combinational signed/unsigned compare, and a multi-cycle sequential signed/unsigned divider with start/busy/done handshake. It feeds the ALU's sum, slt/sltu/seq and div/divu (lo/hi) paths. Quotient and remainder are registered and hold until the next division completes.

---
 rtl/add_cmp_div_unit_pkg.sv | 13 +
 rtl/add_cmp_div_unit_if.sv | 36 +++
 rtl/add_cmp_div_unit_seq_divider_core.sv | 115 +++++++++++
 rtl/add_cmp_div_unit.sv | 42 ++++
 tb/tb_add_cmp_div_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/add_cmp_div_unit_pkg.sv
// Shared constants and divider state encoding
// for the add/compare/divide ALU slice.
package add_cmp_div_unit_pkg;

  localparam int DefaultBits = 32;

  typedef enum logic [1:0] {
    DivIdle,
    DivRun,
    DivFin
  } divState_t;

endpackage

// File: rtl/add_cmp_div_unit_if.sv
// Operand/result bundle between the ALU
// and the add/compare/divide slice.
interface add_cmp_div_unit_if #(
  parameter int BITS = 32
);

  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic            sub;
  logic            unsign;
  logic            div_start;
  logic [BITS-1:0] sum;
  logic            carry_out;
  logic            less_than;
  logic            equal;
  logic            busy;
  logic            done;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            divide_by_zero;

  modport master (
    output a, b, sub, unsign, div_start,
    input  sum, carry_out, less_than, equal,
    input  busy, done, quotient, remainder,
    input  divide_by_zero
  );

  modport slave (
    input  a, b, sub, unsign, div_start,
    output sum, carry_out, less_than, equal,
    output busy, done, quotient, remainder,
    output divide_by_zero
  );

endinterface

// File: rtl/add_cmp_div_unit_seq_divider_core.sv
// Restoring shift-subtract divider, one quotient
// bit per cycle, with sign fixup on the last edge.
module seq_divider_core
  import add_cmp_div_unit_pkg::*;
#(
  parameter int BITS = DefaultBits
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            unsign,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            divideByZero
);

  localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;

  divState_t state;
  divState_t stateNext;

  logic [BITS-1:0] q;
  logic [BITS-1:0] rem;
  logic [BITS-1:0] dvsr;
  logic [BITS-1:0] capA;
  logic            negQ;
  logic            negR;
  logic            zero;
  logic [CW-1:0]   cnt;

  logic            sgnA;
  logic            sgnB;
  logic [BITS-1:0] magA;
  logic [BITS-1:0] magB;
  logic [BITS:0]   shifted;
  logic [BITS:0]   diff;

  assign sgnA = !unsign && a[BITS-1];
  assign sgnB = !unsign && b[BITS-1];
  assign magA = sgnA ? -a : a;
  assign magB = sgnB ? -b : b;

  // rem < dvsr always, so diff MSB is a clean borrow flag
  assign shifted = {rem, q[BITS-1]};
  assign diff    = shifted - {1'b0, dvsr};

  assign busy = (state != DivIdle);

  always_comb begin
    stateNext = state;
    unique case (state)
      DivIdle: if (start) stateNext = DivRun;
      DivRun:
        if (cnt == CW'(BITS - 1))
          stateNext = DivFin;
      DivFin:  stateNext = DivIdle;
      default: stateNext = DivIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= DivIdle;
      done         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      divideByZero <= 1'b0;
      q            <= '0;
      rem          <= '0;
      dvsr         <= '0;
      capA         <= '0;
      negQ         <= 1'b0;
      negR         <= 1'b0;
      zero         <= 1'b0;
      cnt          <= '0;
    end else begin
      state <= stateNext;
      done  <= 1'b0;
      unique case (state)
        DivIdle: begin
          if (start) begin
            q    <= magA;
            rem  <= '0;
            dvsr <= magB;
            capA <= a;
            negQ <= sgnA ^ sgnB;
            negR <= sgnA;
            zero <= (b == '0);
            cnt  <= '0;
          end
        end
        DivRun: begin
          q   <= {q[BITS-2:0], !diff[BITS]};
          rem <= diff[BITS] ? shifted[BITS-1:0]
                            : diff[BITS-1:0];
          cnt <= cnt + 1'b1;
        end
        DivFin: begin
          quotient     <= zero ? '1
                        : (negQ ? -q : q);
          remainder    <= zero ? capA
                        : (negR ? -rem : rem);
          divideByZero <= zero;
          done         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/add_cmp_div_unit.sv
// ALU integer slice: combinational add/sub and
// compare, plus a sequential divider.
module add_cmp_div_unit
  import add_cmp_div_unit_pkg::*;
#(
  parameter int BITS = DefaultBits
) (
  input logic              clk,
  input logic              reset,
  add_cmp_div_unit_if.slave bus
);

  logic [BITS-1:0] bOp;

  // subtract as a + ~b + 1 so carry_out means no borrow
  assign bOp = bus.sub ? ~bus.b : bus.b;
  assign {bus.carry_out, bus.sum} =
    {1'b0, bus.a} + {1'b0, bOp}
    + {{BITS{1'b0}}, bus.sub};

  assign bus.equal = (bus.a == bus.b);
  assign bus.less_than = bus.unsign
    ? (bus.a < bus.b)
    : ($signed(bus.a) < $signed(bus.b));

  seq_divider_core #(
    .BITS(BITS)
  ) uDiv (
    .clk          (clk),
    .reset        (reset),
    .a            (bus.a),
    .b            (bus.b),
    .unsign       (bus.unsign),
    .start        (bus.div_start),
    .busy         (bus.busy),
    .done         (bus.done),
    .quotient     (bus.quotient),
    .remainder    (bus.remainder),
    .divideByZero (bus.divide_by_zero)
  );

endmodule

// File: tb/tb_add_cmp_div_unit.sv
// Scoreboard bench for add_cmp_div_unit:
// directed add/compare vectors and divisions.
module tb_add_cmp_div_unit;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cycle = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  add_cmp_div_unit_if #(.BITS(32)) bus ();

  add_cmp_div_unit #(.BITS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // monitor: every done pulse must match the queue head
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got 1 expected 0");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_q"}, bus.quotient, e.q);
        chk({e.name, "_r"}, bus.remainder, e.r);
        chk({e.name, "_dz"},
            {31'd0, bus.divide_by_zero},
            {31'd0, e.dz});
        chk({e.name, "_lat"}, cycle, e.cyc);
      end
    end
  end

  // call at a negedge; returns at the negedge showing done
  task automatic divOp(string nm,
                       logic [31:0] va,
                       logic [31:0] vb,
                       logic u,
                       logic [31:0] eq,
                       logic [31:0] er,
                       logic edz);
    exp_t e;
    bit seen;
    bus.a = va;
    bus.b = vb;
    bus.unsign = u;
    bus.div_start = 1'b1;
    e.q = eq; e.r = er; e.dz = edz;
    e.cyc = cycle + 34;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.div_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got 0 expected 1", nm);
    end
  endtask

  initial begin
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    bus.unsign = 1'b0;
    bus.div_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_q", bus.quotient, 32'd0);
    chk("rst_r", bus.remainder, 32'd0);
    chk("rst_dz", {31'd0, bus.divide_by_zero}, 32'd0);

    // add/sub
    bus.a = 32'hFFFF_FFFF; bus.b = 32'd1; bus.sub = 0;
    #1;
    chk("add_sum", bus.sum, 32'd0);
    chk("add_co", {31'd0, bus.carry_out}, 32'd1);
    bus.a = 32'd5; bus.b = 32'd7; bus.sub = 1;
    #1;
    chk("sub1_sum", bus.sum, 32'hFFFF_FFFE);
    chk("sub1_co", {31'd0, bus.carry_out}, 32'd0);
    bus.a = 32'd7; bus.b = 32'd5;
    #1;
    chk("sub2_sum", bus.sum, 32'd2);
    chk("sub2_co", {31'd0, bus.carry_out}, 32'd1);
    bus.sub = 0;

    // compare
    bus.a = 32'hFFFF_FFFF; bus.b = 32'd1;
    bus.unsign = 0;
    #1;
    chk("lt_signed", {31'd0, bus.less_than}, 32'd1);
    bus.unsign = 1;
    #1;
    chk("lt_unsigned", {31'd0, bus.less_than}, 32'd0);
    chk("ne_equal", {31'd0, bus.equal}, 32'd0);
    bus.a = 32'h1234; bus.b = 32'h1234;
    #1;
    chk("eq_equal", {31'd0, bus.equal}, 32'd1);
    chk("eq_lt", {31'd0, bus.less_than}, 32'd0);

    @(negedge clk);
    divOp("du1", 32'd100, 32'd7, 1,
          32'd14, 32'd2, 0);
    divOp("du2", 32'hFFFF_FFFF, 32'd2, 1,
          32'h7FFF_FFFF, 32'd1, 0);
    divOp("ds1", -32'sd7, 32'd2, 0,
          32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    divOp("ds2", 32'd7, -32'sd2, 0,
          32'hFFFF_FFFD, 32'd1, 0);
    divOp("dovf", 32'h8000_0000, 32'hFFFF_FFFF, 0,
          32'h8000_0000, 32'd0, 0);
    divOp("dz1", 32'd42, 32'd0, 1,
          32'hFFFF_FFFF, 32'd42, 1);
    divOp("dz2", 32'hFFFF_FFFB, 32'd0, 0,
          32'hFFFF_FFFF, 32'hFFFF_FFFB, 1);
    divOp("dclr", 32'd9, 32'd3, 1,
          32'd3, 32'd0, 0);

    // start while busy and operand changes are ignored
    begin
      exp_t e;
      bus.a = 32'd100; bus.b = 32'd7; bus.unsign = 1;
      bus.div_start = 1'b1;
      e.q = 32'd14; e.r = 32'd2; e.dz = 0;
      e.cyc = cycle + 34; e.name = "dbusy";
      sb.push_back(e);
      @(negedge clk);
      bus.a = 32'd1000; bus.b = 32'd3;
      @(negedge clk);
      chk("busy_hi", {31'd0, bus.busy}, 32'd1);
      bus.div_start = 1'b0;
      bus.a = 32'd55; bus.b = 32'd5;
      repeat (40) @(negedge clk);
      chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    end

    // reset mid-operation aborts without done
    bus.a = 32'd77; bus.b = 32'd4; bus.unsign = 1;
    bus.div_start = 1'b1;
    @(negedge clk);
    bus.div_start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_q", bus.quotient, 32'd0);
    chk("abort_r", bus.remainder, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_idle", {31'd0, bus.busy}, 32'd0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d expected 0",
               sb.size());
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
